// File: rtl/mac_pkg.sv
// Shared definitions for the multiplier-accumulator datapath storage cells:
// default reset/clear values and the next-state mux selector of a register bit.
package mac_pkg;

    // The datapath relies on both the async reset and the sync clear producing 0.
    localparam logic RST_VAL_DEF  = 1'b0;
    localparam logic INIT_VAL_DEF = 1'b0;

    // Which source feeds the storage flop on the next rising edge.
    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_INIT = 2'd2
    } next_sel_e;

    // Priority encoding of the control pins: init0 beats ld, ld beats hold.
    function automatic next_sel_e pick_sel(input logic ld, input logic init0);
        next_sel_e sel;
        sel = SEL_HOLD;
        if (init0) begin
            sel = SEL_INIT;
        end else if (ld) begin
            sel = SEL_LOAD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/reg_1b_nextsel.sv
// Combinational priority mux producing the D input of a register bit.
// The data input only reaches D on a plain load, so an unknown data bit
// cannot leak into the flop while the cell is holding or clearing.
module reg_1b_nextsel
    import mac_pkg::*;
#(
    parameter logic INIT_VAL = INIT_VAL_DEF
) (
    input  logic      ld,
    input  logic      init0,
    input  logic      data_in,
    input  logic      cur_val,
    output next_sel_e sel,
    output logic      d
);

    // Select the source first, then steer exactly one value onto D.
    always_comb begin
        sel = pick_sel(ld, init0);
        d   = cur_val;
        unique case (sel)
            SEL_INIT: d = INIT_VAL;
            SEL_LOAD: d = data_in;
            SEL_HOLD: d = cur_val;
            default:  d = cur_val;
        endcase
    end

endmodule

// File: rtl/reg_1b.sv
// Single-bit storage cell: asynchronous active-low clear, synchronous clear
// (init0) and synchronous load (ld). Bit-slice of the datapath N-bit register;
// the output is taken straight from the flop.
module reg_1b
    import mac_pkg::*;
#(
    parameter logic RST_VAL  = RST_VAL_DEF,
    parameter logic INIT_VAL = INIT_VAL_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ld,
    input  logic init0,
    input  logic in,
    output logic out
);

    logic      out_q;
    logic      out_d;
    next_sel_e sel;

    reg_1b_nextsel #(
        .INIT_VAL (INIT_VAL)
    ) u_nextsel (
        .ld      (ld),
        .init0   (init0),
        .data_in (in),
        .cur_val (out_q),
        .sel     (sel),
        .d       (out_d)
    );

    // Storage flop; the clear acts without a clock and overrides any edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= RST_VAL;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

`ifndef SYNTHESIS
    // While reset is held the bit must sit at its reset value.
    a_rst_val: assert property (@(posedge clk) !rst |-> out_q == RST_VAL)
        else $error("reg_1b: out not at reset value while rst low");

    // A plain load shows the sampled data bit one edge later.
    a_load: assert property (@(posedge clk) disable iff (!rst)
        (rst && ld && !init0) |=> out_q === $past(in))
        else $error("reg_1b: load did not capture in");

    // A sync clear yields the init value one edge later, whatever ld/in were.
    a_init: assert property (@(posedge clk) disable iff (!rst)
        (rst && init0) |=> out_q == INIT_VAL)
        else $error("reg_1b: init0 did not clear");

    // With neither control set the bit holds.
    a_hold: assert property (@(posedge clk) disable iff (!rst)
        (rst && !ld && !init0) |=> $stable(out_q))
        else $error("reg_1b: out changed while holding");

    // Corner cases the integration wants to see exercised.
    c_init_and_ld: cover property (@(posedge clk) rst && init0 && ld && sel == SEL_INIT);
    c_ld_in0:      cover property (@(posedge clk) rst && sel == SEL_LOAD && !in);
    c_ld_in1:      cover property (@(posedge clk) rst && sel == SEL_LOAD && in);
    c_rst_with_ld: cover property (@(posedge clk) !rst && ld);
`endif

endmodule

// File: tb/tb_reg_1b.sv
// Directed and randomised check of the single-bit register cell against
// hand-computed values and a small behavioural model.
module tb_reg_1b;

    localparam logic INIT_V = 1'b0;

    logic clk;
    logic rst;
    logic ld;
    logic init0;
    logic in_s;
    logic out_s;

    int total = 0;
    int bad   = 0;

    reg_1b dut (
        .clk   (clk),
        .rst   (rst),
        .ld    (ld),
        .init0 (init0),
        .in    (in_s),
        .out   (out_s)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic exp);
        total++;
        assert (out_s === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, out_s, exp);
        end
        $display("check %-14s out=%b exp=%b", tag, out_s, exp);
    endtask

    logic model;
    logic v;

    initial begin
        rst   = 1'b1;
        ld    = 1'b0;
        init0 = 1'b0;
        in_s  = 1'b0;

        // 1: async clear at t=5 with ld low and an unknown data bit
        #5;
        rst  = 1'b0;
        in_s = 1'bx;
        #1 chk("rst_async", 1'b0);
        @(negedge clk) chk("rst_held_1", 1'b0);
        @(negedge clk) chk("rst_held_2", 1'b0);
        rst = 1'b1;
        @(negedge clk) chk("rst_release", 1'b0);

        // 2: data present but ld low for three cycles, then load
        in_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) chk("hold_ld0", 1'b0);
        end
        ld = 1'b1;
        @(negedge clk) chk("load_1", 1'b1);

        // 3: hold with data changing, reload, then track a toggling input
        ld   = 1'b0;
        in_s = 1'b0;
        @(negedge clk) chk("hold_1_a", 1'b1);
        @(negedge clk) chk("hold_1_b", 1'b1);
        ld = 1'b1;
        @(negedge clk) chk("load_0", 1'b0);
        v = 1'b0;
        for (int i = 0; i < 6; i++) begin
            v    = ~v;
            in_s = v;
            @(negedge clk) chk("track", v);
        end

        // 4: init0 beats ld, then load resumes
        in_s = 1'b1;
        @(negedge clk) chk("preset_1", 1'b1);
        init0 = 1'b1;
        @(negedge clk) chk("init_wins", INIT_V);
        init0 = 1'b0;
        @(negedge clk) chk("load_after_in", 1'b1);
        ld    = 1'b0;
        init0 = 1'b1;
        @(negedge clk) chk("init_no_ld", INIT_V);
        init0 = 1'b0;
        ld    = 1'b1;
        @(negedge clk) chk("reload_1", 1'b1);

        // 5: reset between edges while ld is high
        #2 rst = 1'b0;
        #1 chk("rst_mid", 1'b0);
        @(negedge clk) chk("rst_mid_held", 1'b0);
        rst = 1'b1;
        ld  = 1'b0;
        @(negedge clk) chk("rst_rel_hold", 1'b0);
        ld = 1'b1;
        @(negedge clk) chk("rst_rel_load", 1'b1);

        // 6: random traffic against a behavioural model
        rst = 1'b0;
        ld  = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
        model = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("rand", model);
            rst   = ($urandom_range(0, 15) != 0);
            ld    = 1'($urandom_range(0, 1));
            init0 = ($urandom_range(0, 3) == 0);
            in_s  = 1'($urandom_range(0, 1));
            if (!rst) begin
                model = 1'b0;
                #1 chk("rand_async", model);
            end
            @(posedge clk);
            if (rst) begin
                if (init0) begin
                    model = INIT_V;
                end else if (ld) begin
                    model = in_s;
                end
            end
        end
        @(negedge clk) chk("rand_last", model);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
